greenpak_page_writer: RTL and testbench

//  Port-2 consumer of the 256x8 Nios II shared image RAM. On start it reads the GreenPAK image from the
//  RAM and programs the target in PAGE_BYTES-byte I2C page writes: START+ctrl, word addr, data (STOP on last).

---
 rtl/greenpak_page_writer_pkg.sv | 23 ++
 rtl/greenpak_page_writer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_greenpak_page_writer.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/greenpak_page_writer_pkg.sv
// Shared types and constants for the GreenPAK page writer.
package greenpak_page_writer_pkg;

    localparam int unsigned PAGE_BYTES_DEF = 16;
    localparam int unsigned MEM_DEPTH      = 256;

    // R/W bit of the I2C control byte; page programming is always a write.
    localparam logic I2C_WRITE_BIT = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CTRL,
        ST_WADDR,
        ST_FETCH,
        ST_LATCH,
        ST_DATA,
        ST_TWR,
        ST_FIN,
        ST_ABORT,
        ST_ERR
    } state_t;

endpackage

// File: rtl/greenpak_page_writer.sv
// Reads the GreenPAK image from the shared RAM and programs it in I2C page writes.
module greenpak_page_writer
    import greenpak_page_writer_pkg::*;
#(
    parameter int unsigned PAGE_BYTES = PAGE_BYTES_DEF,
    parameter int unsigned TWR_CYCLES = 1000000,
    parameter int unsigned TWR_W      = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] slave_ctrl,
    input  logic [3:0] first_page,
    input  logic [4:0] num_pages,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] err_page,
    output logic [7:0] mem_address,
    output logic       mem_chipselect,
    output logic       mem_clken,
    input  logic [7:0] mem_readdata,
    output logic       i2c_cmd_valid,
    input  logic       i2c_cmd_ready,
    output logic       i2c_cmd_start,
    output logic       i2c_cmd_stop,
    output logic       i2c_cmd_nodata,
    output logic [7:0] i2c_cmd_data,
    input  logic       i2c_rsp_valid,
    input  logic       i2c_rsp_nack
);

    localparam int unsigned IDX_W      = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
    localparam int unsigned PAGE_COUNT = MEM_DEPTH / PAGE_BYTES;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAGE_BYTES - 1);
    localparam logic [TWR_W-1:0] TWR_LAST = TWR_W'(TWR_CYCLES - 1);

    // RAM byte address of a byte within a page; 8-bit wrap is intentional.
    function automatic logic [7:0] byte_addr(input logic [3:0] pg, input logic [IDX_W-1:0] ix);
        return 8'(32'(pg) * PAGE_BYTES + 32'(ix));
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       page_q, page_d;
    logic [4:0]       left_q, left_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TWR_W-1:0] twr_q, twr_d;
    logic [7:0]       ctrl_q, ctrl_d;
    logic             wait_q, wait_d;

    logic       busy_d, done_d, error_d;
    logic [3:0] err_page_d;
    logic [7:0] addr_d;
    logic       cs_d, clken_d;
    logic       valid_d, cstart_d, cstop_d, cnodata_d;
    logic [7:0] cdata_d;

    logic cmd_fire;
    logic rsp_take;
    logic [7:0] ctrl_in;

    assign cmd_fire = i2c_cmd_valid && i2c_cmd_ready;
    assign rsp_take = wait_q && i2c_rsp_valid;
    assign ctrl_in  = {slave_ctrl[7:1], I2C_WRITE_BIT};

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            page_q         <= '0;
            left_q         <= '0;
            idx_q          <= '0;
            twr_q          <= '0;
            ctrl_q         <= '0;
            wait_q         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_page       <= '0;
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            mem_clken      <= 1'b0;
            i2c_cmd_valid  <= 1'b0;
            i2c_cmd_start  <= 1'b0;
            i2c_cmd_stop   <= 1'b0;
            i2c_cmd_nodata <= 1'b0;
            i2c_cmd_data   <= '0;
        end else begin
            state_q        <= state_d;
            page_q         <= page_d;
            left_q         <= left_d;
            idx_q          <= idx_d;
            twr_q          <= twr_d;
            ctrl_q         <= ctrl_d;
            wait_q         <= wait_d;
            busy           <= busy_d;
            done           <= done_d;
            error          <= error_d;
            err_page       <= err_page_d;
            mem_address    <= addr_d;
            mem_chipselect <= cs_d;
            mem_clken      <= clken_d;
            i2c_cmd_valid  <= valid_d;
            i2c_cmd_start  <= cstart_d;
            i2c_cmd_stop   <= cstop_d;
            i2c_cmd_nodata <= cnodata_d;
            i2c_cmd_data   <= cdata_d;
        end
    end

    // Next-state and next-output logic; command fields hold unless a new command is loaded.
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        left_d     = left_q;
        idx_d      = idx_q;
        twr_d      = twr_q;
        ctrl_d     = ctrl_q;
        wait_d     = wait_q;
        busy_d     = busy;
        done_d     = 1'b0;
        error_d    = error;
        err_page_d = err_page;
        addr_d     = mem_address;
        cs_d       = 1'b0;
        clken_d    = 1'b0;
        valid_d    = i2c_cmd_valid;
        cstart_d   = i2c_cmd_start;
        cstop_d    = i2c_cmd_stop;
        cnodata_d  = i2c_cmd_nodata;
        cdata_d    = i2c_cmd_data;

        if (cmd_fire) begin
            valid_d = 1'b0;
            wait_d  = 1'b1;
        end
        if (rsp_take) begin
            wait_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (6'(first_page) + 6'(num_pages) > 6'(PAGE_COUNT)) begin
                        error_d    = 1'b1;
                        err_page_d = first_page;
                    end else if (num_pages == 5'd0) begin
                        error_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        error_d   = 1'b0;
                        busy_d    = 1'b1;
                        page_d    = first_page;
                        left_d    = num_pages;
                        ctrl_d    = ctrl_in;
                        valid_d   = 1'b1;
                        cstart_d  = 1'b1;
                        cstop_d   = 1'b0;
                        cnodata_d = 1'b0;
                        cdata_d   = ctrl_in;
                        state_d   = ST_CTRL;
                    end
                end
            end
            ST_CTRL, ST_WADDR: begin
                if (rsp_take) begin
                    if (i2c_rsp_nack) begin
                        valid_d   = 1'b1;
                        cstart_d  = 1'b0;
                        cstop_d   = 1'b1;
                        cnodata_d = 1'b1;
                        state_d   = ST_ABORT;
                    end else if (state_q == ST_CTRL) begin
                        valid_d  = 1'b1;
                        cstart_d = 1'b0;
                        cdata_d  = byte_addr(page_q, '0);
                        state_d  = ST_WADDR;
                    end else begin
                        idx_d   = '0;
                        addr_d  = byte_addr(page_q, '0);
                        cs_d    = 1'b1;
                        clken_d = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                // The command data register doubles as the read-data holding register.
                valid_d = 1'b1;
                cdata_d = mem_readdata;
                cstop_d = (idx_q == IDX_LAST);
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (rsp_take) begin
                    if (i2c_cmd_stop) begin
                        if (i2c_rsp_nack) begin
                            // STOP already on the bus, so no separate stop-only command.
                            error_d    = 1'b1;
                            err_page_d = page_q;
                            busy_d     = 1'b0;
                            cstop_d    = 1'b0;
                            cdata_d    = '0;
                            state_d    = ST_ERR;
                        end else begin
                            twr_d   = '0;
                            state_d = ST_TWR;
                        end
                    end else if (i2c_rsp_nack) begin
                        valid_d   = 1'b1;
                        cstart_d  = 1'b0;
                        cstop_d   = 1'b1;
                        cnodata_d = 1'b1;
                        state_d   = ST_ABORT;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        addr_d  = byte_addr(page_q, idx_q + IDX_W'(1));
                        cs_d    = 1'b1;
                        clken_d = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_TWR: begin
                if (twr_q == TWR_LAST) begin
                    if (left_q == 5'd1) begin
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        cstop_d  = 1'b0;
                        cdata_d  = '0;
                        state_d  = ST_FIN;
                    end else begin
                        page_d    = page_q + 4'd1;
                        left_d    = left_q - 5'd1;
                        valid_d   = 1'b1;
                        cstart_d  = 1'b1;
                        cstop_d   = 1'b0;
                        cnodata_d = 1'b0;
                        cdata_d   = ctrl_q;
                        state_d   = ST_CTRL;
                    end
                end else begin
                    twr_d = twr_q + TWR_W'(1);
                end
            end
            ST_ABORT: begin
                if (rsp_take) begin
                    error_d    = 1'b1;
                    err_page_d = page_q;
                    busy_d     = 1'b0;
                    cstop_d    = 1'b0;
                    cnodata_d  = 1'b0;
                    cdata_d    = '0;
                    state_d    = ST_ERR;
                end
            end
            ST_FIN, ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_greenpak_page_writer.sv
// Directed bench for greenpak_page_writer with RAM and I2C engine models.
module tb_greenpak_page_writer;

    localparam int unsigned PB      = 16;
    localparam int unsigned TWR     = 10;
    localparam int          RSP_DLY = 2;

    logic       clk, reset, start;
    logic [7:0] slave_ctrl;
    logic [3:0] first_page;
    logic [4:0] num_pages;
    logic       busy, done, error;
    logic [3:0] err_page;
    logic [7:0] mem_address, mem_readdata;
    logic       mem_chipselect, mem_clken;
    logic       i2c_cmd_valid, i2c_cmd_ready, i2c_cmd_start, i2c_cmd_stop, i2c_cmd_nodata;
    logic [7:0] i2c_cmd_data;
    logic       i2c_rsp_valid, i2c_rsp_nack;

    int n_checks = 0;
    int n_fail   = 0;

    greenpak_page_writer #(.PAGE_BYTES(PB), .TWR_CYCLES(TWR), .TWR_W(20)) dut (
        .clk(clk), .reset(reset), .start(start), .slave_ctrl(slave_ctrl),
        .first_page(first_page), .num_pages(num_pages), .busy(busy), .done(done),
        .error(error), .err_page(err_page), .mem_address(mem_address),
        .mem_chipselect(mem_chipselect), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .i2c_cmd_valid(i2c_cmd_valid), .i2c_cmd_ready(i2c_cmd_ready),
        .i2c_cmd_start(i2c_cmd_start), .i2c_cmd_stop(i2c_cmd_stop),
        .i2c_cmd_nodata(i2c_cmd_nodata), .i2c_cmd_data(i2c_cmd_data),
        .i2c_rsp_valid(i2c_rsp_valid), .i2c_rsp_nack(i2c_rsp_nack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Image RAM model: registered address, data one cycle later.
    logic [7:0] mem [256];
    logic [7:0] ram_q;
    initial for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11) ^ 8'h5C;
    always @(posedge clk) if (mem_chipselect && mem_clken) ram_q <= mem[mem_address];
    assign mem_readdata = ram_q;

    // I2C engine model and traffic logs, evaluated on the falling edge.
    logic [7:0] c_data [$];
    logic [2:0] c_flags [$];
    int         c_cyc [$];
    int         rsp_cyc [$];
    logic [7:0] rd_addr [$];
    int   cyc = 0, done_cnt = 0, stall_left = 0, nack_idx = -1, rsp_wait = 0;
    logic rsp_nack_pend = 1'b0, prev_valid = 1'b0;

    initial begin
        i2c_cmd_ready = 1'b0;
        i2c_rsp_valid = 1'b0;
        i2c_rsp_nack  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            i2c_rsp_valid = 1'b0;
            i2c_rsp_nack  = 1'b0;
            if (reset) rsp_wait = 0;
            if (rsp_wait > 0) begin
                rsp_wait--;
                if (rsp_wait == 0) begin
                    i2c_rsp_valid = 1'b1;
                    i2c_rsp_nack  = rsp_nack_pend;
                    rsp_cyc.push_back(cyc);
                end
            end
            if (done) done_cnt++;
            if (mem_chipselect && mem_clken) rd_addr.push_back(mem_address);
            if (i2c_cmd_valid && !prev_valid) begin
                c_data.push_back(i2c_cmd_data);
                c_flags.push_back({i2c_cmd_start, i2c_cmd_stop, i2c_cmd_nodata});
                c_cyc.push_back(cyc);
            end
            prev_valid = i2c_cmd_valid;
            if (i2c_cmd_valid && stall_left > 0) begin
                i2c_cmd_ready = 1'b0;
                stall_left--;
            end else if (i2c_cmd_valid && !reset) begin
                i2c_cmd_ready = 1'b1;
                rsp_wait      = RSP_DLY;
                rsp_nack_pend = ((c_data.size() - 1) == nack_idx);
            end else begin
                i2c_cmd_ready = 1'b0;
            end
        end
    end

    task automatic pulse_start(input logic [7:0] c, input logic [3:0] fp, input logic [4:0] np);
        @(negedge clk); #1;
        start = 1'b1; slave_ctrl = c; first_page = fp; num_pages = np;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; slave_ctrl = '0; first_page = '0; num_pages = '0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({busy, done, error, err_page} !== 7'd0) begin
            n_fail++; $display("FAIL reset_status: got %b required 0", {busy, done, error, err_page});
        end
        n_checks++;
        if ({mem_address, mem_chipselect, mem_clken} !== 10'd0) begin
            n_fail++; $display("FAIL reset_mem: got %h required 0", {mem_address, mem_chipselect, mem_clken});
        end
        n_checks++;
        if ({i2c_cmd_valid, i2c_cmd_start, i2c_cmd_stop, i2c_cmd_nodata, i2c_cmd_data} !== 12'd0) begin
            n_fail++; $display("FAIL reset_cmd: got %h required 0",
                               {i2c_cmd_valid, i2c_cmd_start, i2c_cmd_stop, i2c_cmd_nodata, i2c_cmd_data});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_page(input logic [3:0] fp, input logic [7:0] ctrl);
        int base = c_data.size();
        int rb   = rd_addr.size();
        int db   = done_cnt;
        bit ok;
        logic [7:0] pbase = 8'(fp * PB);
        pulse_start(ctrl, fp, 5'd1);
        wait_end(2000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL page%0d_timeout: busy still %b", fp, busy); end
        n_checks++;
        if (c_data.size() - base != 18) begin
            n_fail++; $display("FAIL page%0d_cmd_count: got %0d required 18", fp, c_data.size() - base);
        end else begin
            n_checks++;
            if ({c_flags[base], c_data[base]} !== {3'b100, ctrl & 8'hFE}) begin
                n_fail++; $display("FAIL page%0d_ctrl: got %h required %h", fp,
                                   {c_flags[base], c_data[base]}, {3'b100, ctrl & 8'hFE});
            end
            n_checks++;
            if ({c_flags[base+1], c_data[base+1]} !== {3'b000, pbase}) begin
                n_fail++; $display("FAIL page%0d_waddr: got %h required %h", fp,
                                   {c_flags[base+1], c_data[base+1]}, {3'b000, pbase});
            end
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if ({c_flags[base+2+i], c_data[base+2+i]} !== {1'b0, i == 15, 1'b0, mem[pbase + 8'(i)]}) begin
                    n_fail++; $display("FAIL page%0d_byte%0d: got %h required %h", fp, i,
                                       {c_flags[base+2+i], c_data[base+2+i]},
                                       {1'b0, i == 15, 1'b0, mem[pbase + 8'(i)]});
                end
            end
        end
        n_checks++;
        if (rd_addr.size() - rb != 16) begin
            n_fail++; $display("FAIL page%0d_reads: got %0d required 16", fp, rd_addr.size() - rb);
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (rd_addr[rb+i] !== pbase + 8'(i)) begin
                    n_fail++; $display("FAIL page%0d_addr%0d: got %h required %h", fp, i, rd_addr[rb+i], pbase + 8'(i));
                end
            end
        end
        n_checks++;
        if (done_cnt - db != 1 || error !== 1'b0) begin
            n_fail++; $display("FAIL page%0d_done: done pulses %0d error %b required 1 and 0", fp, done_cnt - db, error);
        end
    endtask

    task automatic test_range_error();
        int base = c_data.size();
        int rb   = rd_addr.size();
        bit saw_busy = 1'b0;
        pulse_start(8'h11, 4'd15, 5'd2);
        n_checks++;
        if ({error, err_page, busy} !== {1'b1, 4'd15, 1'b0}) begin
            n_fail++; $display("FAIL range_err: got err %b page %0d busy %b required 1 15 0", error, err_page, busy);
        end
        repeat (10) begin
            @(negedge clk); #1;
            if (busy) saw_busy = 1'b1;
        end
        n_checks++;
        if (saw_busy || c_data.size() != base || rd_addr.size() != rb) begin
            n_fail++; $display("FAIL range_quiet: busy %b cmds %0d reads %0d required 0 0 0",
                               saw_busy, c_data.size() - base, rd_addr.size() - rb);
        end
    endtask

    task automatic test_zero_pages();
        int base = c_data.size();
        pulse_start(8'h11, 4'd0, 5'd0);
        n_checks++;
        if ({done, busy, error} !== 3'b100) begin
            n_fail++; $display("FAIL zero_done: got done/busy/err %b required 100", {done, busy, error});
        end
        @(negedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL zero_pulse: done still %b required 0", done); end
        repeat (5) @(negedge clk);
        n_checks++;
        if (c_data.size() != base) begin
            n_fail++; $display("FAIL zero_traffic: got %0d cmds required 0", c_data.size() - base);
        end
    endtask

    task automatic test_nack();
        int base = c_data.size();
        int rb   = rd_addr.size();
        bit ok;
        nack_idx = base + 3;
        pulse_start(8'h11, 4'd3, 5'd1);
        wait_end(2000, ok);
        repeat (20) @(negedge clk);
        #1;
        nack_idx = -1;
        n_checks++;
        if (!ok || c_data.size() - base != 5) begin
            n_fail++; $display("FAIL nack_cmds: ok %b got %0d cmds required 5", ok, c_data.size() - base);
        end else begin
            n_checks++;
            if (c_flags[base+4] !== 3'b011) begin
                n_fail++; $display("FAIL nack_stop_only: got flags %b required 011", c_flags[base+4]);
            end
        end
        n_checks++;
        if ({error, err_page, busy} !== {1'b1, 4'd3, 1'b0}) begin
            n_fail++; $display("FAIL nack_status: got err %b page %0d busy %b required 1 3 0", error, err_page, busy);
        end
        n_checks++;
        if (rd_addr.size() - rb != 2) begin
            n_fail++; $display("FAIL nack_reads: got %0d required 2", rd_addr.size() - rb);
        end
    endtask

    task automatic test_stall();
        int base = c_data.size();
        int lows = 0;
        bit stable = 1'b1;
        bit ok;
        logic [10:0] first;
        stall_left = 5;
        pulse_start(8'h11, 4'd1, 5'd1);
        first = {i2c_cmd_start, i2c_cmd_stop, i2c_cmd_nodata, i2c_cmd_data};
        for (int i = 0; i < 50; i++) begin
            if (!(i2c_cmd_valid && !i2c_cmd_ready)) break;
            lows++;
            if ({i2c_cmd_start, i2c_cmd_stop, i2c_cmd_nodata, i2c_cmd_data} !== first) stable = 1'b0;
            @(negedge clk); #1;
        end
        n_checks++;
        if (lows != 5 || !stable || first !== {3'b100, 8'h10}) begin
            n_fail++; $display("FAIL stall_hold: low cycles %0d stable %b fields %h required 5 1 410", lows, stable, first);
        end
        wait_end(2000, ok);
        n_checks++;
        if (!ok || c_data.size() - base != 18 || error !== 1'b0) begin
            n_fail++; $display("FAIL stall_complete: ok %b cmds %0d err %b required 1 18 0", ok, c_data.size() - base, error);
        end
    endtask

    task automatic test_multi_twr();
        int base = c_data.size();
        int rbs  = rsp_cyc.size();
        int db   = done_cnt;
        bit ok;
        pulse_start(8'h11, 4'd4, 5'd3);
        wait_end(3000, ok);
        n_checks++;
        if (!ok || c_data.size() - base != 54 || rsp_cyc.size() - rbs != 54) begin
            n_fail++; $display("FAIL multi_count: ok %b cmds %0d rsps %0d required 1 54 54",
                               ok, c_data.size() - base, rsp_cyc.size() - rbs);
        end else begin
            for (int p = 1; p < 3; p++) begin
                n_checks++;
                if (c_cyc[base+18*p] - rsp_cyc[rbs+18*p-1] != TWR + 1 || c_flags[base+18*p] !== 3'b100) begin
                    n_fail++; $display("FAIL multi_twr%0d: gap %0d flags %b required %0d 100", p,
                                       c_cyc[base+18*p] - rsp_cyc[rbs+18*p-1], c_flags[base+18*p], TWR + 1);
                end
                n_checks++;
                if (c_data[base+18*p+1] !== 8'(16 * (4 + p))) begin
                    n_fail++; $display("FAIL multi_waddr%0d: got %h required %h", p, c_data[base+18*p+1], 8'(16 * (4 + p)));
                end
            end
        end
        n_checks++;
        if (done_cnt - db != 1) begin n_fail++; $display("FAIL multi_done: got %0d pulses required 1", done_cnt - db); end
    endtask

    task automatic test_busy_ignore();
        int base = c_data.size();
        bit ok;
        pulse_start(8'h11, 4'd5, 5'd1);
        repeat (3) @(negedge clk);
        pulse_start(8'h33, 4'd0, 5'd16);
        wait_end(2000, ok);
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if (!ok || c_data.size() - base != 18) begin
            n_fail++; $display("FAIL busy_ignore_count: ok %b got %0d cmds required 18", ok, c_data.size() - base);
        end else begin
            n_checks++;
            if ({c_data[base], c_data[base+1]} !== 16'h1050) begin
                n_fail++; $display("FAIL busy_ignore_fields: got %h required 1050", {c_data[base], c_data[base+1]});
            end
        end
    endtask

    task automatic test_reset_mid();
        int base = c_data.size();
        bit reached = 1'b0;
        pulse_start(8'h11, 4'd2, 5'd1);
        for (int i = 0; i < 200; i++) begin
            if (c_data.size() >= base + 3) begin reached = 1'b1; break; end
            @(negedge clk); #1;
        end
        n_checks++;
        if (!reached || !i2c_cmd_valid) begin
            n_fail++; $display("FAIL midreset_reach: reached %b valid %b required 1 1", reached, i2c_cmd_valid);
        end
        reset = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({busy, done, error, err_page, mem_address, mem_chipselect, mem_clken, i2c_cmd_valid,
             i2c_cmd_start, i2c_cmd_stop, i2c_cmd_nodata, i2c_cmd_data} !== 29'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got %h required 0",
                               {busy, done, error, err_page, mem_address, mem_chipselect, mem_clken, i2c_cmd_valid,
                                i2c_cmd_start, i2c_cmd_stop, i2c_cmd_nodata, i2c_cmd_data});
        end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || c_data.size() != base + 3) begin
            n_fail++; $display("FAIL midreset_quiet: busy %b cmds %0d required 0 3", busy, c_data.size() - base);
        end
    endtask

    initial begin
        test_reset();
        test_single_page(4'd0, 8'h11);
        test_single_page(4'd15, 8'hA1);
        test_range_error();
        test_zero_pages();
        test_nack();
        test_stall();
        test_multi_twr();
        test_busy_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
